// File: rtl/mem_2k_burst_reader_pkg.sv
// Shared types and constants for the frame-RAM burst reader: state encoding,
// the per-read tag that travels alongside the RAM latency, and the default widths.
package mem_rd_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/mem_2k_burst_reader_if.sv
// Command, RAM read port and output stream of the burst reader, bundled together.
// slave is the reader's view, master is the view of whatever drives it.
interface mem_2k_burst_reader_if #(
  parameter int ADDR_W = mem_rd_pkg::ADDR_W,
  parameter int DATA_W = mem_rd_pkg::DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic [ADDR_W-1:0] rdaddress;
  logic [DATA_W-1:0] mem_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, mem_q, out_ready,
    output cmd_ready, rdaddress, out_valid, out_data, out_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, mem_q, out_ready,
    input  cmd_ready, rdaddress, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/mem_rd_skid_fifo.sv
// First-word-fall-through skid FIFO with a write-to-read bypass, so a word
// written into an empty FIFO is visible (and poppable) in the same cycle.
module mem_rd_skid_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             store;
  logic             dequeue;

  // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    empty    = (count_q == '0);
    rd_valid = !empty || wr_en;
    rd_data  = '0;
    if (!empty) begin
      rd_data = data_q[rd_ptr_q];
    end else if (wr_en) begin
      rd_data = wr_data;
    end
    // A write into an empty FIFO that is popped the same cycle passes straight through.
    dequeue  = rd_en && !empty;
    store    = wr_en && !(empty && rd_en);
    wr_ptr_d = wr_ptr_q + PTR_W'(store);
    rd_ptr_d = rd_ptr_q + PTR_W'(dequeue);
    count_d  = count_q + CNT_W'(store) - CNT_W'(dequeue);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; it is never read while count_q says it is empty.
  always_ff @(posedge clk) begin
    if (store) begin
      data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(store && !dequeue && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/mem_2k_burst_reader.sv
// Read-side burst sequencer for the 2048 x 64 frame RAM: issues one address per
// cycle under credit control, tracks the RAM latency with tags, streams words out.
module mem_2k_burst_reader #(
  parameter int ADDR_W     = mem_rd_pkg::ADDR_W,
  parameter int DATA_W     = mem_rd_pkg::DATA_W,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mem_2k_burst_reader_if.slave  bus
);

  import mem_rd_pkg::*;

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2);

  if (FIFO_DEPTH < RD_LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("FIFO_DEPTH must be a power of 2 and at least RD_LATENCY+1");
  end

  rd_state_t                  state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [ADDR_W:0]            remain_q, remain_d;
  logic [ADDR_W-1:0]          rdaddress_q, rdaddress_d;
  rd_tag_t                    iss_tag_q, iss_tag_d;
  rd_tag_t [RD_LATENCY:1]     pipe_q, pipe_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       fifo_rvalid;
  logic [DATA_W:0]            fifo_rdata;
  logic [FCNT_W-1:0]          fifo_count;
  logic [CRED_W-1:0]          credit_used;
  logic                       issue_ok;
  logic                       pop;

  mem_rd_skid_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clock),
    .rst_n    (reset_n),
    .wr_en    (pipe_q[RD_LATENCY].valid),
    .wr_data  ({pipe_q[RD_LATENCY].last, bus.mem_q}),
    .rd_en    (bus.out_ready),
    .rd_valid (fifo_rvalid),
    .rd_data  (fifo_rdata),
    .count    (fifo_count)
  );

  assign pop = fifo_rvalid && bus.out_ready;

  // iss_tag_q lines up with rdaddress; pipe_q[RD_LATENCY] lines up with mem_q.
  always_comb begin
    credit_used = CRED_W'(fifo_count) + CRED_W'(iss_tag_q.valid);
    pipe_d[1]   = iss_tag_q;
    for (int k = 1; k <= RD_LATENCY; k++) begin
      credit_used = credit_used + CRED_W'(pipe_q[k].valid);
      if (k >= 2) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end
    issue_ok = (credit_used < CRED_W'(FIFO_DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    rdaddress_d = rdaddress_q;
    iss_tag_d   = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len != '0) begin
            addr_d   = bus.cmd_addr;
            remain_d = bus.cmd_len;
            busy_d   = 1'b1;
            state_d  = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue_ok) begin
          rdaddress_d     = addr_q;
          addr_d          = addr_q + ADDR_W'(1);
          remain_d        = remain_q - (ADDR_W + 1)'(1);
          iss_tag_d.valid = 1'b1;
          iss_tag_d.last  = (remain_q == (ADDR_W + 1)'(1));
          if (remain_q == (ADDR_W + 1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last-tagged word is always the final one out, so its pop empties everything.
        if (pop && fifo_rdata[DATA_W]) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      rdaddress_q <= '0;
      iss_tag_q   <= '0;
      pipe_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      rdaddress_q <= rdaddress_d;
      iss_tag_q   <= iss_tag_d;
      pipe_q      <= pipe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rdaddress = rdaddress_q;
  assign bus.out_valid = fifo_rvalid;
  assign bus.out_data  = fifo_rdata[DATA_W-1:0];
  assign bus.out_last  = fifo_rvalid && fifo_rdata[DATA_W];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_2k_burst_reader.sv
// Directed bench for the burst reader: a table of bursts with hand-computed
// timing, plus hand-written sequences for ignored commands and mid-burst reset.
module tb_mem_2k_burst_reader;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 64;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    int                stall_after;
    int                stall_cycles;
    logic [ADDR_W-1:0] exp_stall_rdaddr;
    int                exp_first_cyc;
    int                exp_done_cyc;
  } vec_t;

  logic clock;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_2k_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_2k_burst_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LATENCY (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model with mem[i] = i: address register then output register.
  logic [ADDR_W-1:0] ram_addr_q;
  always @(posedge clock) begin
    ram_addr_q <= bus.rdaddress;
    bus.mem_q  <= DATA_W'(ram_addr_q);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycle 0 is the low clock phase right after the accepting edge.
  task automatic run_burst(input vec_t v, input bit inject);
    int                words;
    int                first_cyc;
    int                done_cyc;
    int                done_cnt;
    int                stall_left;
    bit                stalled;
    logic [ADDR_W-1:0] exp_addr;
    words = 0; first_cyc = -1; done_cyc = -1; done_cnt = 0; stall_left = 0; stalled = 0;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    bus.out_ready = 1'b1;
    check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    bus.cmd_valid = inject;
    bus.cmd_addr  = 11'd500;
    bus.cmd_len   = 12'd3;
    check("busy_after_accept", 64'(bus.busy), 64'(v.len != 0));
    for (int cyc = 0; cyc < 300 && !(done_cnt > 0 && cyc > done_cyc + 2); cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (inject && cyc < 3) check("cmd_ignored", 64'(bus.cmd_ready), 64'd0);
      if (cyc == 3) bus.cmd_valid = 1'b0;
      if (cyc == 1 && v.len != 0) check("rdaddress_first", 64'(bus.rdaddress), 64'(v.addr));
      if (!stalled && bus.out_valid && words == v.stall_after && v.stall_cycles > 0) begin
        stalled    = 1'b1;
        stall_left = v.stall_cycles;
      end
      bus.out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        if (stall_left == 1) check("rdaddress_stalled", 64'(bus.rdaddress), 64'(v.exp_stall_rdaddr));
        stall_left--;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check("busy_at_done", 64'(bus.busy), 64'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        exp_addr = v.addr + words[ADDR_W-1:0];
        check("out_data", bus.out_data, 64'(exp_addr));
        check("out_last", 64'(bus.out_last), 64'(words == int'(v.len) - 1));
        words++;
      end
    end
    check("word_count", 64'(words), 64'(v.len));
    check("first_word_cycle", 64'(first_cyc), 64'(v.exp_first_cyc));
    check("done_cycle", 64'(done_cyc), 64'(v.exp_done_cyc));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   words;
    vecs[0] = '{addr: 11'd5,    len: 12'd1,  stall_after: 0, stall_cycles: 0,  exp_stall_rdaddr: 11'd0,   exp_first_cyc: 3,  exp_done_cyc: 4};
    vecs[1] = '{addr: 11'd0,    len: 12'd16, stall_after: 0, stall_cycles: 0,  exp_stall_rdaddr: 11'd0,   exp_first_cyc: 3,  exp_done_cyc: 19};
    vecs[2] = '{addr: 11'd2046, len: 12'd4,  stall_after: 0, stall_cycles: 0,  exp_stall_rdaddr: 11'd0,   exp_first_cyc: 3,  exp_done_cyc: 7};
    vecs[3] = '{addr: 11'd100,  len: 12'd12, stall_after: 2, stall_cycles: 10, exp_stall_rdaddr: 11'd105, exp_first_cyc: 3,  exp_done_cyc: 25};
    vecs[4] = '{addr: 11'd2047, len: 12'd2,  stall_after: 0, stall_cycles: 2,  exp_stall_rdaddr: 11'd0,   exp_first_cyc: 5,  exp_done_cyc: 7};
    vecs[5] = '{addr: 11'd9,    len: 12'd0,  stall_after: 0, stall_cycles: 0,  exp_stall_rdaddr: 11'd0,   exp_first_cyc: -1, exp_done_cyc: 0};

    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    check("rst_out_data",  bus.out_data,       64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_done",      64'(bus.done),      64'd0);
    check("rst_rdaddress", 64'(bus.rdaddress), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i], 1'b0);
    end

    // A command offered while a burst is running must be ignored, not queued.
    v = '{addr: 11'd200, len: 12'd8, stall_after: 0, stall_cycles: 0, exp_stall_rdaddr: 11'd0, exp_first_cyc: 3, exp_done_cyc: 11};
    run_burst(v, 1'b1);

    // Full-size burst, reset asserted once the 20th word has been seen.
    bus.cmd_addr  = 11'd0;
    bus.cmd_len   = 12'd2048;
    bus.cmd_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    words = 0;
    for (int c = 0; c < 100 && words < 20; c++) begin
      if (c > 0) @(negedge clock);
      if (bus.out_valid) words++;
    end
    check("words_before_reset", 64'(words), 64'd20);
    check("busy_before_reset", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("async_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_out_last",  64'(bus.out_last),  64'd0);
    check("async_out_data",  bus.out_data,       64'd0);
    check("async_busy",      64'(bus.busy),      64'd0);
    check("async_done",      64'(bus.done),      64'd0);
    check("async_rdaddress", 64'(bus.rdaddress), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    v = '{addr: 11'd7, len: 12'd2, stall_after: 0, stall_cycles: 0, exp_stall_rdaddr: 11'd0, exp_first_cyc: 3, exp_done_cyc: 5};
    run_burst(v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "time limit");
  end

endmodule
